memory_stage: RTL
=================

Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the ALU result as a byte address and the forwarded rt value as store data.
- Performs byte/half/word loads and stores on an internal data RAM and sign/zero-extends loads.
- Registers everything into the MEM/WB latch that feeds write-back; provides a debug read port for the debug unit.

Parameters:
- NB, 32, datapath width
- NB_ADDR, 10, byte-address bits used; depth = 2**(NB_ADDR-2) words
- NB_REG, 5, register-file index width

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_step  in  1  pipeline advance enable from the debug unit; 0 = hold
- i_alu_result  in  NB  byte address / pass-through ALU value
- i_data_b  in  NB  store data
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_word_size  in  2  00 byte, 01 half, 11 word; 10 illegal
- i_signed  in  1  1 = sign-extend load (LB/LH), 0 = zero-extend (LBU/LHU)
- i_reg_write  in  1  write-back enable, passed through
- i_mem_to_reg  in  1  write-back mux select, passed through
- i_rd  in  NB_REG  destination register, passed through
- i_debug_addr  in  NB_ADDR-2  debug word index
- o_read_data  out  NB  registered extended load data
- o_alu_result  out  NB  registered pass-through
- o_reg_write  out  1  registered, gated by fault
- o_mem_to_reg  out  1  registered
- o_rd  out  NB_REG  registered
- o_misaligned  out  1  registered fault flag
- o_debug_data  out  NB  registered debug word

Behaviour:
- Reset (i_reset=0, async):
  - All outputs are 0, including o_debug_data.
  - RAM contents are not cleared; they are undefined until written.
- Address handling:
  - Word index = i_alu_result[NB_ADDR-1:2]; lane = i_alu_result[1:0].
  - Upper address bits are ignored, so accesses wrap modulo depth.
- Misalignment: half with lane[0]=1, word with lane!=00, or size=10 while i_mem_read or i_mem_write is set. On a misaligned access:
  - No RAM write occurs.
  - At the next edge, o_misaligned=1, o_reg_write=0, o_read_data=0.
- Store (i_mem_write=1, aligned, i_step=1): at the rising edge, writes the low bytes of i_data_b into the selected lanes, little-endian.
  - Byte: i_data_b[7:0] goes to lane.
  - Half: [15:0] goes to lanes {lane+1, lane}.
  - Word: all 4 lanes.
  - Other lanes are unchanged.
- Load (i_mem_read=1, aligned): extracts the selected byte/half/word from the current RAM word and extends it per i_signed.
  - Word loads ignore i_signed.
  - The result is registered into o_read_data at the edge; latency is 1 cycle.
- i_mem_read and i_mem_write both 1: the store is performed and o_read_data=0. The bench must flag this as a protocol error; the RTL does not.
- Neither read nor write: o_read_data=0.
- Same-address load on the cycle after a store returns the new data, because the RAM write completes at the edge.
- i_step=0:
  - No RAM write.
  - All MEM/WB outputs hold their values.
  - The debug port still updates.
- Debug port: o_debug_data is the RAM word at i_debug_addr, registered every edge, independent of i_step. Latency is 1 cycle.

Decomposition:
- Shared package `mem_pkg`:
  - Size codes SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11.
  - Lane-mask generation function.
  - Extension function.
- Sub-module `data_memory`:
  - Byte-lane write-enable RAM, 4x8-bit lanes.
  - Combinational read port and registered debug read port.
- memory_stage holds alignment check, lane select/extension and the MEM/WB latch.

Test Plan:
- Reset mid-operation: after 0x11223344 is loaded onto o_read_data, drop i_reset for 1 cycle -> all outputs 0 immediately; a later read of the same address returns 0x11223344.
- Word store/load: SW 0x8000_00F1 at 0x010, then LW 0x010 -> o_read_data=0x8000_00F1 one cycle after the LW, o_reg_write follows input.
- Byte/half extension, starting from word 0x8000_00F1 at 0x010:
  - LB 0x010 -> 0xFFFF_FFF1.
  - LBU 0x010 -> 0x0000_00F1.
  - LH 0x012 -> 0xFFFF_8000.
  - LHU 0x012 -> 0x0000_8000.
- Partial store: SB 0xAB at 0x011, then LW 0x010 -> 0x8000_ABF1; SH 0x1234 at 0x012 -> 0x1234_ABF1.
- Misalignment: LW at 0x012 with i_reg_write=1 -> o_misaligned=1, o_reg_write=0, o_read_data=0; SH at 0x011 -> memory unchanged (LW 0x010 still 0x1234_ABF1).
- Stall and debug:
  - i_step=0 with SW 0xDEADBEEF at 0x020 -> outputs held, and a debug read of word 8 does not return 0xDEADBEEF.
  - Raising i_step commits the store -> debug word 8 = 0xDEADBEEF one cycle later.
  - Address 0x420 aliases to 0x020 (NB_ADDR=10).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access size codes, byte-lane
// write-mask generation and load-data extension.
package mem_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Byte lanes touched by an access of the given size at the given lane.
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size,
                                                       input logic [1:0] lane);
        logic [NUM_LANES-1:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << lane;
            SIZE_HALF: m = 4'b0011 << lane;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // Pull the addressed byte/half out of a RAM word and extend it.
    // Word loads ignore the signed flag.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sgn);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: r = {{24{sgn & s[7]}}, s[7:0]};
            SIZE_HALF: r = {{16{sgn & s[15]}}, s[15:0]};
            SIZE_WORD: r = word;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// EX -> MEM inputs and MEM/WB outputs of the memory stage, plus the debug port.
interface memory_stage_if #(
    parameter int NB      = 32,
    parameter int NB_ADDR = 10,
    parameter int NB_REG  = 5
);
    logic                 i_step;
    logic [NB-1:0]        i_alu_result;
    logic [NB-1:0]        i_data_b;
    logic                 i_mem_read;
    logic                 i_mem_write;
    logic [1:0]           i_word_size;
    logic                 i_signed;
    logic                 i_reg_write;
    logic                 i_mem_to_reg;
    logic [NB_REG-1:0]    i_rd;
    logic [NB_ADDR-3:0]   i_debug_addr;

    logic [NB-1:0]        o_read_data;
    logic [NB-1:0]        o_alu_result;
    logic                 o_reg_write;
    logic                 o_mem_to_reg;
    logic [NB_REG-1:0]    o_rd;
    logic                 o_misaligned;
    logic [NB-1:0]        o_debug_data;

    modport slave (
        input  i_step, i_alu_result, i_data_b, i_mem_read, i_mem_write,
               i_word_size, i_signed, i_reg_write, i_mem_to_reg, i_rd,
               i_debug_addr,
        output o_read_data, o_alu_result, o_reg_write, o_mem_to_reg, o_rd,
               o_misaligned, o_debug_data
    );

    modport master (
        output i_step, i_alu_result, i_data_b, i_mem_read, i_mem_write,
               i_word_size, i_signed, i_reg_write, i_mem_to_reg, i_rd,
               i_debug_addr,
        input  o_read_data, o_alu_result, o_reg_write, o_mem_to_reg, o_rd,
               o_misaligned, o_debug_data
    );
endinterface

// File: rtl/memory_stage_data_memory.sv
// Data RAM with per-byte-lane write enables, a combinational read port for
// the pipeline and a registered debug read port. Contents are not reset.
module data_memory
    import mem_pkg::*;
#(
    parameter int NB_ADDR = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_ADDR-3:0]   i_addr,
    input  logic [NUM_LANES-1:0] i_we,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata,
    input  logic [NB_ADDR-3:0]   i_debug_addr,
    output logic [31:0]          o_debug_data
);
    localparam int DEPTH = 2 ** (NB_ADDR - 2);

    logic [NUM_LANES-1:0][7:0] mem [DEPTH];
    logic [31:0]               debug_d;
    logic [31:0]               debug_q;

    // Byte-lane writes; unselected lanes keep their contents.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (i_we[l]) mem[i_addr][l] <= i_wdata[8*l +: 8];
        end
    end

    assign o_rdata = mem[i_addr];

    // Debug word lookup, sampled every edge regardless of pipeline stalls.
    always_comb begin
        debug_d = mem[i_debug_addr];
    end

    // Debug output register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) debug_q <= '0;
        else          debug_q <= debug_d;
    end

    assign o_debug_data = debug_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: alignment check, store lane steering, load extension and the
// MEM/WB latch. The latch only advances when i_step is high.
module memory_stage
    import mem_pkg::*;
#(
    parameter int NB      = 32,
    parameter int NB_ADDR = 10,
    parameter int NB_REG  = 5
) (
    input  logic           i_clk,
    input  logic           i_reset,
    memory_stage_if.slave  bus
);
    logic [NB_ADDR-3:0]   word_idx;
    logic [1:0]           lane;
    logic                 access;
    logic                 misaligned;
    logic [NUM_LANES-1:0] we;
    logic [31:0]          wdata;
    logic [31:0]          ram_rdata;
    logic [NB-1:0]        load_data;

    logic [NB-1:0]        read_data_d,  read_data_q;
    logic [NB-1:0]        alu_result_d, alu_result_q;
    logic                 reg_write_d,  reg_write_q;
    logic                 mem_to_reg_d, mem_to_reg_q;
    logic [NB_REG-1:0]    rd_d,         rd_q;
    logic                 misaligned_d, misaligned_q;

    // Address decode, fault detection, write steering and load extraction.
    always_comb begin
        word_idx   = bus.i_alu_result[NB_ADDR-1:2];
        lane       = bus.i_alu_result[1:0];
        access     = bus.i_mem_read | bus.i_mem_write;
        misaligned = access &&
                     ((bus.i_word_size == SIZE_HALF && lane[0]) ||
                      (bus.i_word_size == SIZE_WORD && lane != 2'b00) ||
                      (bus.i_word_size == 2'b10));
        // Replicate the low bytes across lanes; the mask picks the live ones.
        case (bus.i_word_size)
            SIZE_BYTE: wdata = {4{bus.i_data_b[7:0]}};
            SIZE_HALF: wdata = {2{bus.i_data_b[15:0]}};
            default:   wdata = bus.i_data_b[31:0];
        endcase
        we = '0;
        if (bus.i_mem_write && !misaligned && bus.i_step)
            we = lane_mask(bus.i_word_size, lane);
        load_data = '0;
        // A store alongside a load wins; the load returns zero.
        if (bus.i_mem_read && !bus.i_mem_write && !misaligned)
            load_data = extend_load(ram_rdata, bus.i_word_size, lane, bus.i_signed);
    end

    data_memory #(.NB_ADDR(NB_ADDR)) u_ram (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_addr       (word_idx),
        .i_we         (we),
        .i_wdata      (wdata),
        .o_rdata      (ram_rdata),
        .i_debug_addr (bus.i_debug_addr),
        .o_debug_data (bus.o_debug_data)
    );

    // MEM/WB next state: hold on stall, otherwise capture; faults kill write-back.
    always_comb begin
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        misaligned_d = misaligned_q;
        if (bus.i_step) begin
            read_data_d  = load_data;
            alu_result_d = bus.i_alu_result;
            reg_write_d  = bus.i_reg_write & ~misaligned;
            mem_to_reg_d = bus.i_mem_to_reg;
            rd_d         = bus.i_rd;
            misaligned_d = misaligned;
        end
    end

    // MEM/WB latch.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.o_read_data  = read_data_q;
    assign bus.o_alu_result = alu_result_q;
    assign bus.o_reg_write  = reg_write_q;
    assign bus.o_mem_to_reg = mem_to_reg_q;
    assign bus.o_rd         = rd_q;
    assign bus.o_misaligned = misaligned_q;

endmodule
